// File: rtl/median_if.sv
//------------------------------------------------------------------------------
// median_if : sample stream in / median result out for the median block
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface median_if;
   logic       DSI;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       DSO;

   modport master (output DSI, output DI, input DO, input DSO);
   modport slave  (input DSI, input DI, output DO, output DSO);
endinterface

`default_nettype wire

// File: rtl/median.sv
//------------------------------------------------------------------------------
// median : 9-sample, 8-bit running-window median using a single comparator
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module median (
   input  wire logic CLK,
   input  wire logic nRST,
   median_if.slave   bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [2:0] C_LAST_CYC  = 3'd7;
   localparam logic [2:0] C_LAST_PASS = 3'd4;

   logic [0:0] r_state;
   logic [0:0] w_state_nxt;

   logic [7:0] r_smp [0:8];
   logic [8:0] r_vld;
   logic [2:0] r_pass;
   logic [2:0] r_cyc;
   logic [8:0] r_best;
   logic [3:0] r_bidx;
   logic       r_seen;
   logic [7:0] r_do;
   logic       r_dso;

   logic       w_shift;
   logic       w_start;
   logic       w_step;
   logic       w_done;
   logic       w_last_cyc;

   // Keys are {valid, value} so discarded entries lose every comparison.
   logic [3:0] w_nidx;
   logic [8:0] w_nkey;
   logic [8:0] w_cand;
   logic [3:0] w_cidx;
   logic       w_take;
   logic [8:0] w_win;
   logic [3:0] w_widx;

   assign w_nidx = {1'b0, r_cyc} + 4'd1;
   assign w_nkey = {r_vld[w_nidx], r_smp[w_nidx]};
   assign w_cand = (r_cyc == 3'd0) ? {r_vld[0], r_smp[0]} : r_best;
   assign w_cidx = (r_cyc == 3'd0) ? 4'd0 : r_bidx;
   assign w_take = (w_nkey > w_cand);
   assign w_win  = w_take ? w_nkey : w_cand;
   assign w_widx = w_take ? w_nidx : w_cidx;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_done)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_shift    = 1'b0;
      w_start    = 1'b0;
      w_step     = 1'b0;
      w_last_cyc = (r_cyc == C_LAST_CYC);
      case (r_state)
         S_IDLE: begin
            w_shift = bus.DSI;
            w_start = !bus.DSI && r_seen;
         end
         S_RUN:   w_step = 1'b1;
         default: ;
      endcase
      w_done = w_step && w_last_cyc && (r_pass == C_LAST_PASS);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < 9; k++) r_smp[k] <= '0;
         r_vld  <= '0;
         r_pass <= '0;
         r_cyc  <= '0;
         r_best <= '0;
         r_bidx <= '0;
         r_seen <= 1'b0;
         r_do   <= '0;
         r_dso  <= 1'b0;
      end else begin
         r_dso <= w_done;
         if (w_shift) begin
            r_smp[0] <= bus.DI;
            for (int k = 1; k < 9; k++) r_smp[k] <= r_smp[k-1];
            r_seen <= 1'b1;
         end
         if (w_start) begin
            r_seen <= 1'b0;
            r_vld  <= '1;
            r_pass <= '0;
            r_cyc  <= '0;
         end
         if (w_step) begin
            r_best <= w_win;
            r_bidx <= w_widx;
            r_cyc  <= r_cyc + 3'd1;
            // End of a pass: drop one maximum, or publish it on the final pass.
            if (w_last_cyc) begin
               r_pass <= r_pass + 3'd1;
               if (r_pass != C_LAST_PASS) r_vld[w_widx] <= 1'b0;
               else                       r_do <= w_win[7:0];
            end
         end
      end
   end

   assign bus.DO  = r_do;
   assign bus.DSO = r_dso;

endmodule

`default_nettype wire

// File: tb/tb_median.sv
//------------------------------------------------------------------------------
// tb_median : table vectors, corner sequences and random frames for median
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_median;

   logic CLK = 1'b0;
   logic nRST;
   median_if bus();

   median u_dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [8:0][7:0] s;
      logic [7:0]      exp;
      bit              hold_chk;
   } vec_t;

   int n_pass = 0;
   int n_tot  = 0;
   logic [7:0] hist [9];

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [7:0] ref_median();
      int a [9];
      int t;
      for (int i = 0; i < 9; i++) a[i] = int'(hist[i]);
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] < a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[4][7:0];
   endfunction

   task automatic clr_model();
      for (int i = 0; i < 9; i++) hist[i] = 8'd0;
   endtask

   task automatic send(input logic [7:0] s);
      @(negedge CLK);
      bus.DSI = 1'b1;
      bus.DI  = s;
      for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
   endtask

   // Drops DSI, waits for the result pulse and checks latency and value.
   task automatic finish_frame(input string name, input logic [7:0] exp,
                               input bit hold_chk, input bit noise);
      int seen_at;
      seen_at = -1;
      @(negedge CLK);
      bus.DSI = 1'b0;
      for (int n = 0; n <= 50; n++) begin
         @(negedge CLK);
         if (bus.DSO) begin seen_at = n; break; end
         if (noise && n < 39) begin
            bus.DSI = 1'($urandom_range(0, 1));
            bus.DI  = 8'($urandom);
         end else begin
            bus.DSI = 1'b0;
         end
      end
      bus.DSI = 1'b0;
      chk({name, "_latency"}, seen_at, 40);
      chk({name, "_do"}, int'(bus.DO), int'(exp));
      if (hold_chk) begin
         repeat (3) @(negedge CLK);
         chk({name, "_dso_low"}, int'(bus.DSO), 0);
         chk({name, "_do_hold"}, int'(bus.DO), int'(exp));
      end
   endtask

   task automatic send_vec(input logic [8:0][7:0] s);
      for (int i = 0; i < 9; i++) send(s[i]);
   endtask

   vec_t tbl [4];
   int   dso_cnt;

   initial begin
      tbl[0].s = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      tbl[0].exp = 8'd50;  tbl[0].hold_chk = 1'b0;
      tbl[1].s = {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
      tbl[1].exp = 8'd255; tbl[1].hold_chk = 1'b0;
      tbl[2].s = {9{8'd7}};
      tbl[2].exp = 8'd7;   tbl[2].hold_chk = 1'b0;
      tbl[3].s = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      tbl[3].exp = 8'd5;   tbl[3].hold_chk = 1'b1;

      bus.DSI = 1'b0;
      bus.DI  = 8'd0;
      nRST    = 1'b0;
      clr_model();
      #2;
      chk("reset_do", int'(bus.DO), 0);
      chk("reset_dso", int'(bus.DSO), 0);
      repeat (3) @(negedge CLK);
      nRST = 1'b1;

      for (int v = 0; v < 4; v++) begin
         send_vec(tbl[v].s);
         finish_frame($sformatf("vec%0d", v), tbl[v].exp, tbl[v].hold_chk, 1'b0);
      end

      // Back-to-back: second frame rises the cycle after the pulse.
      for (int i = 1; i <= 9; i++) send(8'(i));
      finish_frame("b2b_a", 8'd5, 1'b0, 1'b0);
      send_vec({8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd100});
      finish_frame("b2b_b", 8'd0, 1'b1, 1'b0);

      // Long frame keeps the last nine, short frame reuses stale entries.
      for (int i = 0; i < 12; i++) send(8'(20 * i + 3));
      finish_frame("long", ref_median(), 1'b0, 1'b0);
      send(8'd250); send(8'd251); send(8'd252);
      finish_frame("short", ref_median(), 1'b0, 1'b0);

      // Reset during RUN aborts with no pulse.
      send_vec(tbl[0].s);
      @(negedge CLK);
      bus.DSI = 1'b0;
      repeat (10) @(negedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk("abort_do", int'(bus.DO), 0);
      chk("abort_dso", int'(bus.DSO), 0);
      clr_model();
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      dso_cnt = 0;
      repeat (50) begin
         @(negedge CLK);
         if (bus.DSO) dso_cnt++;
      end
      chk("abort_no_pulse", dso_cnt, 0);
      send_vec(tbl[0].s);
      finish_frame("after_abort", 8'd50, 1'b0, 1'b0);

      for (int f = 0; f < 1000; f++) begin
         int len;
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 9;
         for (int i = 0; i < len; i++) send(8'($urandom));
         finish_frame($sformatf("rand%0d", f), ref_median(), 1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/median.md
MEDIAN -- requirements
Module: median

Interface
REQ-001 Parameters: none; data width fixed at 8 bits, window size fixed at 9 samples.
REQ-002 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 nRST  input  1  reset; asynchronous, active-low.
REQ-004 DSI  input  1  input data strobe; high while valid samples are presented on DI, one sample per cycle.
REQ-005 DI  input  8  unsigned input sample, sampled on rising CLK while DSI=1.
REQ-006 DO  output  8  unsigned median result, registered.
REQ-007 DSO  output  1  output strobe; one-cycle pulse marking DO valid.

Function
REQ-008 A frame SHALL be 9 consecutive cycles with DSI=1, each carrying one unsigned sample on DI.
REQ-009 While DSI=1, each rising edge SHALL shift DI into a 9-entry register chain, R0<=DI, Rk<=Rk-1.
REQ-010 If DSI stays high more than 9 cycles, only the last 9 samples SHALL be retained.
REQ-011 If DSI stays high fewer than 9 cycles, the missing entries SHALL be the stale register contents (not an error).
REQ-012 The first cycle with DSI=0 after at least one DSI=1 cycle SHALL start processing (state IDLE -> RUN).
REQ-013 RUN SHALL consist of 5 passes of 8 cycles each, 40 cycles total.
REQ-014 Each pass SHALL use one 8-bit unsigned comparator per cycle to locate the maximum of the current pool, with no pipelined multi-comparator sort.
REQ-015 Passes 1-4 SHALL each discard the pool maximum, removing one instance only when duplicates exist.
REQ-016 Pass 5 SHALL take the maximum of the remaining 5 values; this is the 5th largest of the 9, i.e. the median.
REQ-017 At the end of pass 5, DO SHALL be loaded with the median and DSO SHALL be 1 for exactly one cycle.
REQ-018 DSO SHALL rise on the 40th rising edge after the first DSI=0 edge, well within the 50-cycle bound.
REQ-019 After the DSO cycle, the state SHALL return to IDLE.
REQ-020 DO SHALL hold its value until the next result or reset.
REQ-021 DSI=1 while in RUN SHALL be ignored and SHALL NOT corrupt the computation.
REQ-022 A new frame MAY begin on the cycle immediately after DSO; back-to-back frames SHALL be supported.
REQ-023 Comparisons SHALL be unsigned over the range 0..255.
REQ-024 Ties SHALL yield the tied value.

Reset
REQ-025 nRST=0 SHALL immediately, without waiting for a clock edge, force: DO=0, DSO=0, state=IDLE, all sample registers=0, pass/cycle counters=0.
REQ-026 Reset asserted mid-frame or mid-RUN SHALL abort the operation with no DSO pulse.
REQ-027 The first frame after reset release SHALL be processed normally.
REQ-028 Behaviour SHALL be defined even if CLK is not yet toggling during reset.

Verification
REQ-029 Frame 10,20,30,40,50,60,70,80,90 -> one DSO pulse 40 cycles after DSI falls, DO=50.
REQ-030 Frame 255,0,255,0,255,0,255,0,255 -> DO=255; frame 7 x9 -> DO=7.
REQ-031 Frame 9,8,7,6,5,4,3,2,1 -> DO=5; DO stays 5 with DSO=0 until the next result.
REQ-032 Two back-to-back frames (second DSI rising the cycle after DSO), 1..9 then 100,200,0,0,0,0,0,0,1 -> DO=5 then DO=0, one DSO pulse each.
REQ-033 nRST pulsed low during RUN -> DO=0 and DSO=0 immediately, no DSO pulse for the aborted frame, next frame correct.
REQ-034 1000 random frames compared against a software sort (descending, index 4) -> zero mismatches; DSO seen within 50 cycles for every frame.
